// File: rtl/axi_if_ksk_axi_pkg.sv
// Shared AXI4 field widths, protocol constants, read-command types and the
// AR legality check for the KSK AXI4 interface.
package axi_if_ksk_axi_pkg;

  localparam int AXI4_ID_W         = 4;
  localparam int AXI4_ADD_W        = 64;
  localparam int AXI4_DATA_W       = 64;
  localparam int AXI4_DATA_BYTES   = 8;
  localparam int AXI4_DATA_BYTES_W = 3;
  localparam int AXI4_LEN_W        = 8;
  localparam int AXI4_LEN_MAX      = 255;
  localparam int AXI4_SIZE_W       = 3;
  localparam int AXI4_BURST_W      = 2;
  localparam int AXI4_RESP_W       = 2;
  localparam int PAGE_BYTES        = 4096;
  localparam int PAGE_BYTES_W      = 12;

  // Word address carried in a command: full byte address minus the byte lane bits.
  localparam int RD_WADD_W  = AXI4_ADD_W - AXI4_DATA_BYTES_W;
  // Width wide enough to hold page offset plus a maximum-length burst in bytes.
  localparam int PAGE_SUM_W = PAGE_BYTES_W + 2;

  localparam logic [AXI4_BURST_W-1:0] AXI4_BURST_INCR  = 2'b01;
  localparam logic [AXI4_RESP_W-1:0]  AXI4_RESP_OKAY   = 2'b00;
  localparam logic [AXI4_RESP_W-1:0]  AXI4_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [AXI4_ID_W-1:0]  id;
    logic [RD_WADD_W-1:0]  word_add;
    logic [AXI4_LEN_W-1:0] len;
    logic                  err;
  } axi_if_ksk_rd_cmd_t;

  typedef struct packed {
    logic [AXI4_ID_W-1:0]   id;
    logic [AXI4_DATA_W-1:0] data;
    logic [AXI4_RESP_W-1:0] resp;
    logic                   last;
  } axi_if_ksk_rd_beat_t;

  // Returns 1 when an AR request cannot be served from the RAM window.
  function automatic logic rd_cmd_err(
    input logic [AXI4_ADD_W-1:0]   addr,
    input logic [AXI4_LEN_W-1:0]   len,
    input logic [AXI4_SIZE_W-1:0]  size,
    input logic [AXI4_BURST_W-1:0] burst,
    input logic [AXI4_ADD_W-1:0]   base,
    input logic [AXI4_ADD_W-1:0]   depth
  );
    logic [AXI4_ADD_W-1:0] first_w;
    logic [AXI4_ADD_W-1:0] last_w;
    logic [PAGE_SUM_W-1:0] end_b;
    first_w = (addr - base) >> AXI4_DATA_BYTES_W;
    last_w  = first_w + AXI4_ADD_W'(len);
    end_b   = PAGE_SUM_W'(addr[PAGE_BYTES_W-1:0])
            + ((PAGE_SUM_W'(len) + PAGE_SUM_W'(1)) << AXI4_DATA_BYTES_W);
    return (size != AXI4_SIZE_W'(AXI4_DATA_BYTES_W))
         | (burst != AXI4_BURST_INCR)
         | (addr < base)
         | (addr[AXI4_DATA_BYTES_W-1:0] != {AXI4_DATA_BYTES_W{1'b0}})
         | (last_w >= depth)
         | (end_b > PAGE_SUM_W'(PAGE_BYTES));
  endfunction

endpackage

// File: rtl/axi_if_ksk_rd_out_buf.sv
// Two-entry valid/ready buffer for R beats. The head entry drives the R
// channel directly from flops; occupancy is exported for read-credit control.
module axi_if_ksk_rd_out_buf
  import axi_if_ksk_axi_pkg::*;
(
  input  logic                clk_i,
  input  logic                s_rst_n_i,
  input  logic                in_vld_i,
  input  axi_if_ksk_rd_beat_t in_beat_i,
  input  logic                out_rdy_i,
  output logic                out_vld_o,
  output axi_if_ksk_rd_beat_t out_beat_o,
  output logic [1:0]          occ_o
);

  logic [1:0]          cnt_q, cnt_d;
  axi_if_ksk_rd_beat_t head_q, head_d;
  axi_if_ksk_rd_beat_t tail_q, tail_d;
  logic                pop_s;

  assign pop_s      = (cnt_q != 2'd0) & out_rdy_i;
  assign out_vld_o  = (cnt_q != 2'd0);
  assign out_beat_o = head_q;
  assign occ_o      = cnt_q;

  // Next-state of head/tail entries; the upstream credit guarantees no push when full without a pop.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (in_vld_i) begin
          head_d = in_beat_i;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd0;
        end
      end
      2'd1: begin
        if (in_vld_i && pop_s) begin
          head_d = in_beat_i;
        end else if (in_vld_i) begin
          tail_d = in_beat_i;
          cnt_d  = 2'd2;
        end else if (pop_s) begin
          cnt_d  = 2'd0;
        end else begin
          cnt_d  = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_d = tail_q;
          if (in_vld_i) begin
            tail_d = in_beat_i;
          end else begin
            cnt_d  = 2'd1;
          end
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Buffer state register; reset clears the R payload to zero.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/axi_if_ksk_axi_rd_responder.sv
// AXI4 read responder: AR FIFO with per-command legality flag, burst FSM
// issuing one RAM read per credited cycle, and a 2-entry R output buffer.
module axi_if_ksk_axi_rd_responder
  import axi_if_ksk_axi_pkg::*;
#(
  parameter int                    MEM_DEPTH = 1024,
  parameter int                    AR_DEPTH  = 4,
  parameter logic [AXI4_ADD_W-1:0] BASE_ADD  = 64'h0,
  localparam int                   MEM_ADD_W = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    s_rst_n,
  input  logic [AXI4_ID_W-1:0]    s_axi4_arid,
  input  logic [AXI4_ADD_W-1:0]   s_axi4_araddr,
  input  logic [AXI4_LEN_W-1:0]   s_axi4_arlen,
  input  logic [AXI4_SIZE_W-1:0]  s_axi4_arsize,
  input  logic [AXI4_BURST_W-1:0] s_axi4_arburst,
  input  logic                    s_axi4_arvalid,
  output logic                    s_axi4_arready,
  output logic [AXI4_ID_W-1:0]    s_axi4_rid,
  output logic [AXI4_DATA_W-1:0]  s_axi4_rdata,
  output logic [AXI4_RESP_W-1:0]  s_axi4_rresp,
  output logic                    s_axi4_rlast,
  output logic                    s_axi4_rvalid,
  input  logic                    s_axi4_rready,
  input  logic                    ld_en,
  input  logic [MEM_ADD_W-1:0]    ld_add,
  input  logic [AXI4_DATA_W-1:0]  ld_data,
  output logic                    busy
);

  localparam int AR_PTR_W = $clog2(AR_DEPTH);
  localparam int AR_CNT_W = AR_PTR_W + 1;

  // AR FIFO
  axi_if_ksk_rd_cmd_t    ar_fifo_q [AR_DEPTH];
  logic [AR_PTR_W-1:0]   ar_wr_ptr_q, ar_rd_ptr_q;
  logic [AR_CNT_W-1:0]   ar_cnt_q, ar_cnt_d;
  logic                  arready_q, arready_d;
  logic                  ar_push_s, ar_pop_s;
  logic [AXI4_ADD_W-1:0] ar_off_s;
  axi_if_ksk_rd_cmd_t    cmd_in_s, ar_head_s;
  logic                  unused_bits_s;

  // Burst FSM
  rd_state_e             state_q, state_d;
  logic [AXI4_ID_W-1:0]  id_q, id_d;
  logic [MEM_ADD_W-1:0]  wadd_q, wadd_d;
  logic [AXI4_LEN_W-1:0] len_q, len_d;
  logic [AXI4_LEN_W-1:0] beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  issue_s, credit_s;

  // RAM and read pipeline
  logic [AXI4_DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [AXI4_DATA_W-1:0] ram_q;
  logic                   rd_vld_q, rd_last_q, rd_err_q;
  logic [AXI4_ID_W-1:0]   rd_id_q;

  // Output buffer
  axi_if_ksk_rd_beat_t buf_in_s, buf_out_s;
  logic [1:0]          buf_occ_s, occ_nxt_s;
  logic                out_pop_s;
  logic                busy_q, busy_d;

  assign ar_push_s = s_axi4_arvalid & arready_q;
  assign ar_pop_s  = (state_q == ST_IDLE) & (ar_cnt_q != AR_CNT_W'(0));
  assign ar_off_s  = s_axi4_araddr - BASE_ADD;
  assign ar_head_s = ar_fifo_q[ar_rd_ptr_q];

  assign cmd_in_s.id       = s_axi4_arid;
  assign cmd_in_s.word_add = ar_off_s[AXI4_ADD_W-1:AXI4_DATA_BYTES_W];
  assign cmd_in_s.len      = s_axi4_arlen;
  assign cmd_in_s.err      = rd_cmd_err(s_axi4_araddr, s_axi4_arlen, s_axi4_arsize,
                                        s_axi4_arburst, BASE_ADD, AXI4_ADD_W'(MEM_DEPTH));

  // Byte-lane bits and word-address bits above the RAM window are never needed.
  assign unused_bits_s = ^{ar_off_s[AXI4_DATA_BYTES_W-1:0],
                           ar_head_s.word_add[RD_WADD_W-1:MEM_ADD_W]};

  assign ar_cnt_d  = ar_cnt_q + AR_CNT_W'(ar_push_s) - AR_CNT_W'(ar_pop_s);
  assign arready_d = (ar_cnt_d < AR_CNT_W'(AR_DEPTH));

  // AR FIFO storage; entries are fully overwritten before use so they need no reset.
  always_ff @(posedge clk) begin
    if (ar_push_s) begin
      ar_fifo_q[ar_wr_ptr_q] <= cmd_in_s;
    end
  end

  // AR FIFO pointers, occupancy and the registered arready.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      ar_wr_ptr_q <= {AR_PTR_W{1'b0}};
      ar_rd_ptr_q <= {AR_PTR_W{1'b0}};
      ar_cnt_q    <= {AR_CNT_W{1'b0}};
      arready_q   <= 1'b0;
    end else begin
      ar_wr_ptr_q <= ar_push_s ? ar_wr_ptr_q + AR_PTR_W'(1) : ar_wr_ptr_q;
      ar_rd_ptr_q <= ar_pop_s  ? ar_rd_ptr_q + AR_PTR_W'(1) : ar_rd_ptr_q;
      ar_cnt_q    <= ar_cnt_d;
      arready_q   <= arready_d;
    end
  end

  // A read may issue while the buffer plus in-flight read leave a slot, or a beat leaves this cycle.
  assign out_pop_s = s_axi4_rvalid & s_axi4_rready;
  assign credit_s  = ((buf_occ_s + {1'b0, rd_vld_q}) < 2'd2) | out_pop_s;

  // Burst FSM: IDLE pops a command, BURST issues one credited read per cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    wadd_d  = wadd_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    issue_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_pop_s) begin
          state_d = ST_BURST;
          id_d    = ar_head_s.id;
          wadd_d  = ar_head_s.word_add[MEM_ADD_W-1:0];
          len_d   = ar_head_s.len;
          err_d   = ar_head_s.err;
          beat_d  = {AXI4_LEN_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (credit_s) begin
          issue_s = 1'b1;
          beat_d  = beat_q + AXI4_LEN_W'(1);
          wadd_d  = wadd_q + MEM_ADD_W'(1);
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and current-burst registers.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= {AXI4_ID_W{1'b0}};
      wadd_q  <= {MEM_ADD_W{1'b0}};
      len_q   <= {AXI4_LEN_W{1'b0}};
      beat_q  <= {AXI4_LEN_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      wadd_q  <= wadd_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Preload write port; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_add] <= ld_data;
    end
  end

  // Registered RAM read, skipped for error bursts; a same-cycle preload yields the old word.
  always_ff @(posedge clk) begin
    if (issue_s && !err_q) begin
      ram_q <= mem_q[wadd_q];
    end
  end

  // Side-band of the read in flight, aligned with the RAM output register.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_id_q   <= {AXI4_ID_W{1'b0}};
      rd_last_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_vld_q  <= issue_s;
      rd_id_q   <= id_q;
      rd_last_q <= (beat_q == len_q);
      rd_err_q  <= err_q;
    end
  end

  assign buf_in_s.id   = rd_id_q;
  assign buf_in_s.data = rd_err_q ? {AXI4_DATA_W{1'b0}} : ram_q;
  assign buf_in_s.resp = rd_err_q ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
  assign buf_in_s.last = rd_last_q;

  axi_if_ksk_rd_out_buf u_out_buf (
    .clk_i      (clk),
    .s_rst_n_i  (s_rst_n),
    .in_vld_i   (rd_vld_q),
    .in_beat_i  (buf_in_s),
    .out_rdy_i  (s_axi4_rready),
    .out_vld_o  (s_axi4_rvalid),
    .out_beat_o (buf_out_s),
    .occ_o      (buf_occ_s)
  );

  assign occ_nxt_s = buf_occ_s + {1'b0, rd_vld_q} - {1'b0, out_pop_s};
  assign busy_d    = (ar_cnt_d != AR_CNT_W'(0)) | (state_d == ST_BURST) | issue_s
                   | (occ_nxt_s != 2'd0);

  // Registered busy, computed from the next state of every pipeline stage.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign s_axi4_arready = arready_q;
  assign s_axi4_rid     = buf_out_s.id;
  assign s_axi4_rdata   = buf_out_s.data;
  assign s_axi4_rresp   = buf_out_s.resp;
  assign s_axi4_rlast   = buf_out_s.last;
  assign busy           = busy_q;

endmodule

// File: tb/tb_axi_if_ksk_axi_rd_responder.sv
// Scoreboard bench for the KSK AXI4 read responder.
module tb_axi_if_ksk_axi_rd_responder;
  import axi_if_ksk_axi_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int AR_DEPTH  = 4;
  localparam int MEM_ADD_W = 10;

  logic        clk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic [3:0]  arid = 4'd0;
  logic [63:0] araddr = 64'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic        ld_en = 1'b0;
  logic [MEM_ADD_W-1:0] ld_add = '0;
  logic [63:0] ld_data = 64'd0;
  logic        busy;

  axi_if_ksk_axi_rd_responder #(.MEM_DEPTH(MEM_DEPTH), .AR_DEPTH(AR_DEPTH), .BASE_ADD(64'h0)) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .s_axi4_arid(arid), .s_axi4_araddr(araddr), .s_axi4_arlen(arlen),
    .s_axi4_arsize(arsize), .s_axi4_arburst(arburst),
    .s_axi4_arvalid(arvalid), .s_axi4_arready(arready),
    .s_axi4_rid(rid), .s_axi4_rdata(rdata), .s_axi4_rresp(rresp), .s_axi4_rlast(rlast),
    .s_axi4_rvalid(rvalid), .s_axi4_rready(rready),
    .ld_en(ld_en), .ld_add(ld_add), .ld_data(ld_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_beat_t;

  exp_beat_t   sb_q[$];
  logic [63:0] mem_m [MEM_DEPTH];
  int n_vec = 0;
  int n_err = 0;
  int beats_seen = 0;

  // monitor state
  bit          hold_v = 1'b0;
  logic [63:0] hold_data;
  logic [6:0]  hold_ctl;
  bit          prev_v = 1'b0;
  bit          prev_last = 1'b0;
  int          prev_cyc = 0;
  bit          b2b_en = 1'b0;
  bit          gap_en = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // R channel monitor: compares accepted beats to the scoreboard, checks stall stability and spacing.
  always @(negedge clk) begin
    if (s_rst_n) begin
      if (hold_v && rvalid) begin
        check_val("stable_rdata", rdata, hold_data);
        check_val("stable_ctl", 64'({rid, rresp, rlast}), 64'(hold_ctl));
      end
      hold_v    = rvalid && !rready;
      hold_data = rdata;
      hold_ctl  = {rid, rresp, rlast};
      if (rvalid && rready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_beat", 64'(sb_q.size() != 0), 64'd1);
        end else begin
          exp_beat_t e;
          e = sb_q.pop_front();
          check_val("rid", 64'(rid), 64'(e.id));
          check_val("rdata", rdata, e.data);
          check_val("rresp", 64'(rresp), 64'(e.resp));
          check_val("rlast", 64'(rlast), 64'(e.last));
        end
        if (prev_v && b2b_en && !prev_last) check_val("b2b_spacing", 64'(cyc - prev_cyc), 64'd1);
        if (prev_v && gap_en && prev_last)  check_val("burst_bubble", 64'(cyc - prev_cyc), 64'd2);
        prev_v    = 1'b1;
        prev_last = rlast;
        prev_cyc  = cyc;
        beats_seen++;
      end
    end else begin
      hold_v = 1'b0;
      prev_v = 1'b0;
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic ld_word(input int add, input logic [63:0] data);
    ld_en   = 1'b1;
    ld_add  = MEM_ADD_W'(add);
    ld_data = data;
    mem_m[add] = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit exp_err);
    bit accepted = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk);
        accepted = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
          exp_beat_t e;
          e.id   = id;
          e.data = exp_err ? 64'd0 : mem_m[int'(addr >> 3) + b];
          e.resp = exp_err ? 2'b10 : 2'b00;
          e.last = (b == int'(len));
          sb_q.push_back(e);
        end
        #1;
      end else begin
        @(posedge clk); #1;
      end
    end
    arvalid = 1'b0;
    check_val("ar_accept", 64'(accepted), 64'd1);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_val("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    int base;
    bit hit;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_arready", 64'(arready), 64'd0);
    check_val("rst_rvalid", 64'(rvalid), 64'd0);
    check_val("rst_rlast", 64'(rlast), 64'd0);
    check_val("rst_rdata", rdata, 64'd0);
    check_val("rst_rid_rresp", 64'({rid, rresp}), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    s_rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("arready_after_rst", 64'(arready), 64'd1);

    for (int i = 0; i < MEM_DEPTH; i++)
      ld_word(i, {16'hD00D, 16'(i), 32'(i) * 32'h9E37_79B1});
    ld_word(5, 64'hA5A5_A5A5_A5A5_A5A5);

    // single beat with latency: handshake edge T, rvalid rises on edge T+3
    rready = 1'b1;
    send_ar(4'd1, 64'd40, 8'd0, 3'd3, 2'b01, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    check_val("lat_rvalid_T2", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    check_val("lat_rvalid_T3", 64'(rvalid), 64'd1);
    wait_drain(20);

    // full-length burst at page start, back-to-back beats
    prev_v = 1'b0; b2b_en = 1'b1;
    send_ar(4'd2, 64'd0, 8'(AXI4_LEN_MAX), 3'd3, 2'b01, 1'b0);
    wait_drain(400);
    b2b_en = 1'b0;

    // backpressure with random rready
    send_ar(4'd3, 64'd800, 8'd7, 3'd3, 2'b01, 1'b0);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) begin
      rready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_drain(50);

    // outstanding bursts with rready low; one burst sits in the FSM, AR_DEPTH fill the FIFO
    rready = 1'b0;
    for (int k = 0; k < AR_DEPTH + 1; k++)
      send_ar(4'(k % 2), 64'(1600 + 32 * k), 8'd3, 3'd3, 2'b01, 1'b0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) hi_cnt++;
    end
    @(posedge clk); #1;
    check_val("arready_full", 64'(hi_cnt), 64'd0);
    prev_v = 1'b0; b2b_en = 1'b1; gap_en = 1'b1;
    rready = 1'b1;
    send_ar(4'd1, 64'd2400, 8'd3, 3'd3, 2'b01, 1'b0);
    wait_drain(100);
    b2b_en = 1'b0; gap_en = 1'b0;

    // error bursts followed by a legal one
    send_ar(4'd4, 64'd4080, 8'd3, 3'd3, 2'b01, 1'b1);   // crosses 4 KB page
    send_ar(4'd5, 64'd64,   8'd2, 3'd0, 2'b01, 1'b1);   // narrow size
    send_ar(4'd6, 64'd8192, 8'd0, 3'd3, 2'b01, 1'b1);   // beyond RAM
    send_ar(4'd7, 64'd128,  8'd1, 3'd3, 2'b00, 1'b1);   // FIXED burst
    send_ar(4'd8, 64'd136,  8'd1, 3'd3, 2'b01, 1'b0);
    wait_drain(100);

    // reset in the middle of a 16-beat burst, at its 3rd accepted beat
    base = beats_seen;
    send_ar(4'd3, 64'(300 * 8), 8'd15, 3'd3, 2'b01, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (beats_seen - base >= 3) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_val("rst_beat3_reached", 64'(hit), 64'd1);
    s_rst_n = 1'b0;
    rready  = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_rvalid", 64'(rvalid), 64'd0);
    check_val("midrst_arready", 64'(arready), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    rready  = 1'b1;
    @(posedge clk); #1;
    send_ar(4'd9, 64'(600 * 8), 8'd1, 3'd3, 2'b01, 1'b0);
    wait_drain(50);
    repeat (30) @(posedge clk);
    #1;
    check_val("final_busy", 64'(busy), 64'd0);
    check_val("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
